muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Iterative signed MULT/DIV engine plus its sequencer, owning the HI/LO registers.
//   The main control FSM issues MULT/DIV (R-format funct 011000/011010) via a start pulse,
//   stalls on busy, then resumes on done; div-by-zero is reported to exception logic.
//   It replaces the separate mult/div control, himult/lomult and hidiv/lodiv strobes.
//   MFHI/MFLO read hi_out/lo_out directly.
// PARAMETERS
//   WIDTH   32  operand width; HI and LO are WIDTH bits each
//   CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk      in   1      clock, rising-edge
//   reset    in   1      synchronous, active-high reset
//   start    in   1      request; sampled only in IDLE
//   op       in   1      0 = MULT, 1 = DIV; sampled with start
//   a_in     in   WIDTH  rs: multiplicand / dividend (signed); sampled with start
//   b_in     in   WIDTH  rt: multiplier / divisor (signed); sampled with start
//   busy     out  1      high in every state except IDLE
//   done     out  1      one-cycle pulse; HI/LO already hold the new result
//   div0     out  1      one-cycle pulse; DIV with b_in == 0
//   hi_out   out  WIDTH  HI register (MULT upper product / DIV remainder)
//   lo_out   out  WIDTH  LO register (MULT lower product / DIV quotient)
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, div0=0, hi_out=0, lo_out=0; counter and work regs cleared.
//   Reset dominates at any edge, including mid-operation; the partial result is discarded.
//   States: IDLE, PREP, RUN, FIX, DONE, DZ.
//   IDLE: start=1 & op=1 & b_in=0 -> DZ.
//     Otherwise start=1 -> PREP, latching op, operand magnitudes and result sign(s).
//   PREP: one cycle; clear the accumulator/remainder, load counter=WIDTH -> RUN.
//   RUN: exactly WIDTH cycles, one bit per cycle. Counter decrements; leave on count 0 -> FIX.
//     MULT: unsigned shift-add on magnitudes, 2*WIDTH-bit product.
//     DIV: restoring division on magnitudes.
//   FIX: apply signs, then write HI/LO together in this cycle -> DONE.
//     MULT: negate the product if the operand signs differ.
//     DIV: quotient truncates toward zero; its sign is sign(a) XOR sign(b).
//     DIV: remainder takes the sign of the dividend.
//     DIV -2^(WIDTH-1) / -1: LO=0x80000000, HI=0 (wraps; no error flagged).
//   DONE: done=1 for this single cycle -> IDLE.
//   DZ: div0=1 for this single cycle; HI/LO unchanged; done stays 0 -> IDLE.
//   Latency: done is high in the cycle after the (WIDTH+2)th edge following the start edge.
//     That is 35 cycles for WIDTH=32; div0 is high in the cycle right after the start edge.
//   start outside IDLE (including DONE/DZ cycles) is ignored, not queued; the requester
//     must hold start or reissue it.
//   HI/LO change only in FIX, so MFHI/MFLO during busy return the previous result.
//   Arithmetic is modular on WIDTH bits; there is no overflow output (MULT cannot overflow 2*WIDTH).
// TESTING
//   After reset: busy=0, done=0, div0=0, hi_out=0, lo_out=0.
//   MULT 7 x -3 (0x00000007, 0xFFFFFFFD) -> done after 35 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//   MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
//   DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//   DIV 5 / 0 -> div0 pulses one cycle after start, done never asserts, HI/LO keep old values.
//   start pulsed at cycle 10 of a running MULT -> ignored; single done; HI/LO match the first op.
//   reset at cycle 20 of a DIV -> next cycle IDLE, busy=0, HI=LO=0.
//   A new start in the cycle after done is accepted.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine with its own sequencer; owns the HI/LO registers.
// One product/quotient bit per RUN cycle; signs are applied in FIX.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_DZ   = 3'd5;

  logic [2:0]       state_reg;
  logic             op_reg;
  logic             neg_q_reg;   // product / quotient sign: sign(a) ^ sign(b)
  logic             neg_r_reg;   // remainder sign: sign(a)
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] opb_reg;     // |b|: multiplicand or divisor
  logic [WIDTH-1:0] hi_work_reg; // MULT accumulator / DIV partial remainder
  logic [WIDTH-1:0] lo_work_reg; // MULT multiplier bits / DIV dividend -> quotient
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic [WIDTH-1:0]   rem_signed;

  always_comb begin
    mag_a = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    mag_b = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

    // Shift-add: add multiplicand when the current multiplier LSB is set, then shift right.
    mul_sum = {1'b0, hi_work_reg} + (lo_work_reg[0] ? {1'b0, opb_reg} : '0);

    // Restoring division: shift in next dividend bit, keep the difference if no borrow.
    div_shift = {hi_work_reg, lo_work_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_reg};

    prod_mag    = {hi_work_reg, lo_work_reg};
    prod_signed = neg_q_reg ? (~prod_mag + 1'b1) : prod_mag;
    quot_signed = neg_q_reg ? (~lo_work_reg + 1'b1) : lo_work_reg;
    rem_signed  = neg_r_reg ? (~hi_work_reg + 1'b1) : hi_work_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      op_reg      <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      cnt_reg     <= '0;
      opb_reg     <= '0;
      hi_work_reg <= '0;
      lo_work_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (op && (b_in == '0)) begin
              state_reg <= S_DZ;
            end else begin
              state_reg   <= S_PREP;
              op_reg      <= op;
              neg_q_reg   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_r_reg   <= a_in[WIDTH-1];
              opb_reg     <= mag_b;
              lo_work_reg <= mag_a;
            end
          end
        end
        S_PREP: begin
          hi_work_reg <= '0;
          cnt_reg     <= CNT_W'(WIDTH);
          state_reg   <= S_RUN;
        end
        S_RUN: begin
          if (op_reg) begin
            if (!div_diff[WIDTH]) begin
              hi_work_reg <= div_diff[WIDTH-1:0];
              lo_work_reg <= {lo_work_reg[WIDTH-2:0], 1'b1};
            end else begin
              hi_work_reg <= div_shift[WIDTH-1:0];
              lo_work_reg <= {lo_work_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_work_reg <= mul_sum[WIDTH:1];
            lo_work_reg <= {mul_sum[0], lo_work_reg[WIDTH-1:1]};
          end
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) state_reg <= S_FIX;
        end
        S_FIX: begin
          if (op_reg) begin
            hi_reg <= rem_signed;
            lo_reg <= quot_signed;
          end else begin
            hi_reg <= prod_signed[2*WIDTH-1:WIDTH];
            lo_reg <= prod_signed[WIDTH-1:0];
          end
          state_reg <= S_DONE;
        end
        S_DONE:  state_reg <= S_IDLE;
        S_DZ:    state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state_reg != S_IDLE);
  assign done   = (state_reg == S_DONE);
  assign div0   = (state_reg == S_DZ);
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, signed results, div-by-zero,
// ignored start, mid-operation reset and back-to-back issue.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div0(div0), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Issue one op from an IDLE cycle; returns edges from start edge to the done cycle.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int edges);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    while (edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic check_result(input string name, input int edges,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    n_cmp++;
    if (edges !== 34) begin
      n_bad++; $display("FAIL %s latency: got %0d edges, want 34", name, edges);
    end
    n_cmp++;
    if (hi_out !== exp_hi) begin
      n_bad++; $display("FAIL %s hi: got %h, want %h", name, hi_out, exp_hi);
    end
    n_cmp++;
    if (lo_out !== exp_lo) begin
      n_bad++; $display("FAIL %s lo: got %h, want %h", name, lo_out, exp_lo);
    end
    $display("%s: edges=%0d hi=%h lo=%h", name, edges, hi_out, lo_out);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, div0} !== 3'b000) begin
      n_bad++; $display("FAIL reset flags: got %b, want 000", {busy, done, div0});
    end
    n_cmp++;
    if ({hi_out, lo_out} !== 64'h0) begin
      n_bad++; $display("FAIL reset hilo: got %h, want 0", {hi_out, lo_out});
    end
    $display("reset: busy=%b done=%b div0=%b hi=%h lo=%h", busy, done, div0, hi_out, lo_out);
  endtask

  task automatic test_mult;
    int e;
    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, e);
    check_result("mult_7x-3", e, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL mult busy_in_done: got %b, want 1", busy);
    end
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, e);
    check_result("mult_min_x_min", e, 32'h4000_0000, 32'h0000_0000);
  endtask

  task automatic test_div;
    int e;
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, e);
    check_result("div_-7/2", e, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e);
    check_result("div_min/-1", e, 32'h0000_0000, 32'h8000_0000);
  endtask

  // HI/LO still hold the min/-1 result from test_div.
  task automatic test_div0;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a_in = 32'd5; b_in = 32'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({div0, done, busy} !== 3'b101) begin
      n_bad++; $display("FAIL div0 pulse: got div0/done/busy=%b, want 101", {div0, done, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({div0, busy} !== 2'b00) begin
      n_bad++; $display("FAIL div0 single: got div0/busy=%b, want 00", {div0, busy});
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL div0 no_done: got %0d done pulses, want 0", dones);
    end
    n_cmp++;
    if ({hi_out, lo_out} !== {32'h0, 32'h8000_0000}) begin
      n_bad++; $display("FAIL div0 hilo_kept: got %h, want 0000000080000000", {hi_out, lo_out});
    end
    $display("div0_5/0: dones=%0d hi=%h lo=%h", dones, hi_out, lo_out);
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    int dzs = 0;
    int done_edge = -1;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 32'd100; b_in = 32'hFFFF_FF38;  // 100 x -200
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) begin
        start = 1'b1; op = 1'b1; a_in = 32'd9; b_in = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin dones++; done_edge = i; end
      if (div0) dzs++;
    end
    n_cmp++;
    if (dones !== 1 || done_edge !== 34) begin
      n_bad++; $display("FAIL ignore done: got %0d pulses at edge %0d, want 1 at 34", dones, done_edge);
    end
    n_cmp++;
    if (dzs !== 0) begin
      n_bad++; $display("FAIL ignore div0: got %0d pulses, want 0", dzs);
    end
    n_cmp++;
    if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_B1E0) begin
      n_bad++; $display("FAIL ignore result: got %h, want ffffffffffffb1e0", {hi_out, lo_out});
    end
    $display("ignore_start: dones=%0d div0s=%0d hi=%h lo=%h", dones, dzs, hi_out, lo_out);
  endtask

  task automatic test_back_to_back;
    int e;
    run_op(1'b0, 32'd6, 32'd7, e);
    check_result("b2b_mult_6x7", e, 32'h0, 32'd42);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, e);  // -100 / 7, issued in the cycle after done
    check_result("b2b_div_-100/7", e, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, div0} !== 3'b000) begin
      n_bad++; $display("FAIL reset_mid flags: got %b, want 000", {busy, done, div0});
    end
    n_cmp++;
    if ({hi_out, lo_out} !== 64'h0) begin
      n_bad++; $display("FAIL reset_mid hilo: got %h, want 0", {hi_out, lo_out});
    end
    $display("reset_mid: busy=%b hi=%h lo=%h", busy, hi_out, lo_out);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
